// File: rtl/spi_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_mem_arbiter
// Brief    : Shares one SPI mode-0 memory bus between the CPU core and the
//            UART debug/loader path. One word access per 40-bit frame:
//            8-bit command, 16-bit byte address, 16-bit data, MSB first.
//            Word address bit 15 picks the chip select (0 = ROM/cs0,
//            1 = RAM/cs1). Every SPI pin is driven straight from a flop.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   cpu_req    in   CPU request, held with stable fields until cpu_ack
//   cpu_we     in   1 = write, 0 = read
//   cpu_addr   in   [15:0] word address
//   cpu_wdata  in   [15:0] write data
//   cpu_ack    out  one-cycle completion pulse to the CPU
//   dbg_req    in   debug request, same handshake as cpu_req
//   dbg_we     in   1 = write, 0 = read
//   dbg_addr   in   [15:0] word address
//   dbg_wdata  in   [15:0] write data
//   dbg_ack    out  one-cycle completion pulse to the debug path
//   rdata      out  [15:0] read data, valid in the ack cycle, held after
//   busy       out  high from grant through the ack cycle
//   spi_miso   in   target data out
//   spi_cs0    out  ROM chip select, active low
//   spi_cs1    out  RAM chip select, active low
//   spi_clk    out  SCK, idle low
//   spi_mosi   out  controller data out
// ----------------------------------------------------------------------------
// Build option:
//   SPIARB_RR_EN  defined   -> two-way round-robin on simultaneous requests
//                 undefined -> fixed priority, CPU wins every tie
// ============================================================================
module spi_mem_arbiter #(
    parameter logic [7:0] RD_CMD = 8'h03,
    parameter logic [7:0] WR_CMD = 8'h02
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [15:0] rdata,
    output logic        busy,
    input  logic        spi_miso,
    output logic        spi_cs0,
    output logic        spi_cs1,
    output logic        spi_clk,
    output logic        spi_mosi
);

    // Frame length is fixed by the frame structure (cmd + addr + data).
    localparam int         FRAME_BITS = 40;
    localparam logic [5:0] c_LAST_BIT = 6'(FRAME_BITS - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [1:0]            r_state;
    logic                  r_cs0;
    logic                  r_cs1;
    logic                  r_sck;
    logic                  r_mosi;
    logic                  r_cpu_ack;
    logic                  r_dbg_ack;
    logic                  r_busy;
    logic [15:0]           r_rdata;
    logic [FRAME_BITS-1:0] r_frame;
    logic [15:0]           r_rx;
    logic [5:0]            r_bit_cnt;
    logic                  r_we;
    logic                  r_gnt_dbg;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    logic [1:0]            w_state_nxt;
    logic                  w_cs0_nxt;
    logic                  w_cs1_nxt;
    logic                  w_sck_nxt;
    logic                  w_mosi_nxt;
    logic                  w_cpu_ack_nxt;
    logic                  w_dbg_ack_nxt;
    logic                  w_busy_nxt;
    logic [15:0]           w_rdata_nxt;
    logic [FRAME_BITS-1:0] w_frame_nxt;
    logic [15:0]           w_rx_nxt;
    logic [5:0]            w_bit_cnt_nxt;
    logic                  w_we_nxt;
    logic                  w_gnt_dbg_nxt;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                  w_any_req;
    logic                  w_grant_dbg;
    logic                  w_sel_we;
    logic [15:0]           w_sel_addr;
    logic [15:0]           w_sel_wdata;
    logic [FRAME_BITS-1:0] w_new_frame;

    assign w_any_req = cpu_req | dbg_req;

`ifdef SPIARB_RR_EN
    // 1 = debug holds priority on the next tie. Cleared on reset so the
    // CPU is favoured first, then flipped to the loser of every grant.
    logic r_prio_dbg;

    assign w_grant_dbg = dbg_req & (~cpu_req | r_prio_dbg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio_dbg <= 1'b0;
        end else if ((r_state == c_IDLE) && w_any_req) begin
            r_prio_dbg <= ~w_grant_dbg;
        end
    end
`else
    assign w_grant_dbg = dbg_req & ~cpu_req;
`endif

    assign w_sel_we    = w_grant_dbg ? dbg_we    : cpu_we;
    assign w_sel_addr  = w_grant_dbg ? dbg_addr  : cpu_addr;
    assign w_sel_wdata = w_grant_dbg ? dbg_wdata : cpu_wdata;

    // Word address to byte address drops A15 (it became the chip select).
    assign w_new_frame = {(w_sel_we ? WR_CMD : RD_CMD),
                          w_sel_addr[14:0], 1'b0,
                          w_sel_wdata};

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cs0_nxt     = r_cs0;
        w_cs1_nxt     = r_cs1;
        w_sck_nxt     = r_sck;
        w_mosi_nxt    = r_mosi;
        w_cpu_ack_nxt = r_cpu_ack;
        w_dbg_ack_nxt = r_dbg_ack;
        w_busy_nxt    = r_busy;
        w_rdata_nxt   = r_rdata;
        w_frame_nxt   = r_frame;
        w_rx_nxt      = r_rx;
        w_bit_cnt_nxt = r_bit_cnt;
        w_we_nxt      = r_we;
        w_gnt_dbg_nxt = r_gnt_dbg;

        case (r_state)
            c_IDLE: begin
                // Ends the ack pulse of the previous frame; a new grant in
                // this same cycle keeps busy asserted without a gap.
                w_cpu_ack_nxt = 1'b0;
                w_dbg_ack_nxt = 1'b0;
                w_busy_nxt    = 1'b0;
                if (w_any_req) begin
                    w_gnt_dbg_nxt = w_grant_dbg;
                    w_we_nxt      = w_sel_we;
                    w_frame_nxt   = w_new_frame;
                    w_cs0_nxt     = w_sel_addr[15];
                    w_cs1_nxt     = ~w_sel_addr[15];
                    w_mosi_nxt    = w_new_frame[FRAME_BITS-1];
                    w_busy_nxt    = 1'b1;
                    w_bit_cnt_nxt = 6'd0;
                    w_state_nxt   = c_SHIFT;
                end
            end

            c_SHIFT: begin
                if (!r_sck) begin
                    w_sck_nxt = 1'b1;
                end else begin
                    // Falling SCK: capture MISO and present the next bit,
                    // giving MOSI a full clock either side of the rise.
                    w_sck_nxt   = 1'b0;
                    w_rx_nxt    = {r_rx[14:0], spi_miso};
                    w_frame_nxt = {r_frame[FRAME_BITS-2:0], 1'b0};
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_mosi_nxt  = 1'b0;
                        w_state_nxt = c_DONE;
                    end else begin
                        w_mosi_nxt    = r_frame[FRAME_BITS-2];
                        w_bit_cnt_nxt = r_bit_cnt + 6'd1;
                    end
                end
            end

            c_DONE: begin
                // The 16-bit receive register only retains the final 16
                // samples, i.e. the data phase; earlier bits fall out.
                w_cs0_nxt     = 1'b1;
                w_cs1_nxt     = 1'b1;
                w_cpu_ack_nxt = ~r_gnt_dbg;
                w_dbg_ack_nxt = r_gnt_dbg;
                if (!r_we) begin
                    w_rdata_nxt = r_rx;
                end
                w_state_nxt = c_IDLE;
            end

            default: begin
                w_cs0_nxt   = 1'b1;
                w_cs1_nxt   = 1'b1;
                w_sck_nxt   = 1'b0;
                w_mosi_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_cs0     <= 1'b1;
            r_cs1     <= 1'b1;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_dbg_ack <= 1'b0;
            r_busy    <= 1'b0;
            r_rdata   <= 16'h0000;
            r_frame   <= '0;
            r_rx      <= 16'h0000;
            r_bit_cnt <= 6'd0;
            r_we      <= 1'b0;
            r_gnt_dbg <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cs0     <= w_cs0_nxt;
            r_cs1     <= w_cs1_nxt;
            r_sck     <= w_sck_nxt;
            r_mosi    <= w_mosi_nxt;
            r_cpu_ack <= w_cpu_ack_nxt;
            r_dbg_ack <= w_dbg_ack_nxt;
            r_busy    <= w_busy_nxt;
            r_rdata   <= w_rdata_nxt;
            r_frame   <= w_frame_nxt;
            r_rx      <= w_rx_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_we      <= w_we_nxt;
            r_gnt_dbg <= w_gnt_dbg_nxt;
        end
    end

    assign spi_cs0  = r_cs0;
    assign spi_cs1  = r_cs1;
    assign spi_clk  = r_sck;
    assign spi_mosi = r_mosi;
    assign cpu_ack  = r_cpu_ack;
    assign dbg_ack  = r_dbg_ack;
    assign busy     = r_busy;
    assign rdata    = r_rdata;

endmodule
`default_nettype wire
